serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised multi-cycle subtractor that computes D = A − B − bin.
- Each clock cycle it processes STEP bits of the operands, LSB first.
- A registered borrow chains between slices, so one small full-subtractor slice is reused instead of a WIDTH-wide ripple chain.
- Sits in the arithmetic datapath as the sequential successor of the half-subtractor cells, and adds a borrow-in, signed overflow and a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- STEP, 1, bits processed per clock; WIDTH must be a multiple of STEP (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results are updated.
- diff  output  WIDTH  result A−B−bin mod 2^WIDTH.
- bout  output  1  final borrow-out (unsigned underflow: A < B+bin).
- ovf  output  1  signed overflow of the two's-complement subtraction.

Behaviour:
- Reset (rst_n=0, asynchronous, independent of clk):
  - state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0.
  - Internal shift registers, borrow flop and step counter cleared.
  - Reset asserted mid-operation abandons the operation; no done is produced.
- States:
  - IDLE: start=1 → capture a, b, bin into working registers; counter=0; go to RUN. busy rises on the next cycle.
  - RUN: each cycle, slice k (bits k*STEP .. k*STEP+STEP−1) is computed.
    - Per bit: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
    - The borrow ripples within the slice; the slice's final borrow is registered for the next cycle.
    - Difference bits are shifted into a result shift register.
    - counter increments; at counter = WIDTH/STEP − 1 go to IDLE.
- Latency:
  - start accepted at edge T → done=1 during the cycle after edge T + WIDTH/STEP.
  - Example: WIDTH=8, STEP=1 → 8 RUN cycles.
- Completion edge (transition RUN→IDLE):
  - diff, bout, ovf and done=1 are all registered on this edge.
  - ovf = (a[MSB] ^ b[MSB]) & (diff[MSB] ^ a[MSB]), using the captured operands.
- Output holding:
  - done deasserts after one cycle.
  - diff, bout and ovf hold their values until the next completion; they do not change while RUN is in progress.
- busy: 1 in RUN, 0 in IDLE, including the cycle in which done=1.
- Start interactions:
  - start while busy=1 is ignored; the in-flight operation is unaffected.
  - start in the same cycle as done=1 is accepted. Back-to-back throughput is one result per WIDTH/STEP+1 cycles.
- Operand inputs a, b and bin may change freely after capture without affecting the in-flight operation.
- Boundaries:
  - 0−0−1 → diff = all-ones, bout=1.
  - Max−0 → no borrow.
  - With STEP=WIDTH the block completes in 1 RUN cycle.

Test Plan:
- WIDTH=8, STEP=1: a=8'h05, b=8'h03, bin=0 → after 8 RUN cycles done pulse; diff=8'h02, bout=0, ovf=0.
- WIDTH=8, STEP=1: a=8'h00, b=8'h00, bin=1 → diff=8'hFF, bout=1, ovf=0. Also a=8'h03, b=8'h05 → diff=8'hFE, bout=1.
- WIDTH=8, STEP=2: a=8'h80, b=8'h01, bin=0 → done after 4 RUN cycles; diff=8'h7F, bout=0, ovf=1. Also a=8'h7F, b=8'hFF → diff=8'h80, ovf=1, bout=1.
- Handshake, WIDTH=8, STEP=1:
  - Pulse start again mid-RUN with a=8'hAA, b=8'h55 → ignored; original result delivered.
  - start held high through done → second operation accepted in the done cycle; second done exactly 9 cycles after the first.
- Reset: drive rst_n=0 asynchronously 3 cycles into RUN → busy, done, diff, bout and ovf go to 0 immediately. After release with no start, done never pulses; a fresh start then yields correct results.
- Randomised: WIDTH=16, STEP=4, ≥500 random a, b, bin compared against a {bout, diff} = a − b − bin reference model. ovf is checked against the sign rule.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle subtractor computing diff = a - b - bin (mod 2^WIDTH).
//   Each RUN cycle handles STEP bits, LSB first. A single STEP-bit
//   full-subtractor slice is reused, and its borrow is registered between
//   slices.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request an operation (sampled only while busy=0)
//   a, b   minuend / subtrahend, captured on an accepted start
//   bin    borrow-in, captured on an accepted start
//   busy   high while an operation is in progress
//   done   one-cycle pulse when diff/bout/ovf are updated
//   diff   result, held until the next completion
//   bout   final borrow-out (unsigned underflow)
//   ovf    signed two's-complement overflow
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / STEP;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    generate
        if ((STEP < 1) || (WIDTH < 2) || ((WIDTH % STEP) != 0)) begin : g_bad_params
            $error("serial_subtractor: WIDTH must be >= 2 and a multiple of STEP");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
    logic             br, br_chain, slice_br;
    logic             a_msb, b_msb;
    logic [CNT_W-1:0] cnt;
    logic [STEP-1:0]  slice_d;
    logic             last;

    // One STEP-bit ripple slice operating on the low bits of the shifters.
    always_comb begin
        br_chain = br;
        slice_d  = '0;
        for (int unsigned i = 0; i < STEP; i++) begin
            slice_d[i] = a_sh[i] ^ b_sh[i] ^ br_chain;
            br_chain   = (~a_sh[i] & b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & br_chain);
        end
        slice_br = br_chain;
    end

    // New slice enters at the top; after NSLICE shifts slice 0 sits at bit 0.
    always_comb begin
        res_nxt                   = res_sh >> STEP;
        res_nxt[WIDTH-1 -: STEP]  = slice_d;
    end

    assign last = (cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == RUN);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_sh   <= a;
                    b_sh   <= b;
                    br     <= bin;
                    a_msb  <= a[WIDTH-1];
                    b_msb  <= b[WIDTH-1];
                    cnt    <= '0;
                    res_sh <= '0;
                end
            end else begin
                a_sh   <= a_sh >> STEP;
                b_sh   <= b_sh >> STEP;
                br     <= slice_br;
                res_sh <= res_nxt;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    diff <= res_nxt;
                    bout <= slice_br;
                    // Operand sign bits are kept separately since the shifters are consumed.
                    ovf  <= (a_msb ^ b_msb) & (res_nxt[WIDTH-1] ^ a_msb);
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Scoreboard bench for serial_subtractor. Four instances:
//   k=0 WIDTH=8 STEP=1, k=1 WIDTH=8 STEP=2, k=2 WIDTH=16 STEP=4,
//   k=3 WIDTH=8 STEP=8. Expected results (including the cycle in which done
//   must appear) are queued at issue and popped when done is seen.
module tb_serial_subtractor;

    typedef struct packed {
        int          exp_cyc;
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    localparam int WV [4] = '{8, 8, 16, 8};
    localparam int NV [4] = '{8, 4, 4, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_v [4];
    logic [15:0] a_v [4];
    logic [15:0] b_v [4];
    logic        bin_v [4];

    logic        busy_v [4];
    logic        done_v [4];
    logic [15:0] diff_v [4];
    logic        bout_v [4];
    logic        ovf_v [4];

    logic        busy0, busy1, busy2, busy3;
    logic        done0, done1, done2, done3;
    logic [7:0]  diff0, diff1, diff3;
    logic [15:0] diff2;
    logic        bout0, bout1, bout2, bout3;
    logic        ovf0, ovf1, ovf2, ovf3;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cnt [4];
    logic [15:0] last_diff [4];
    exp_t        q [4][$];
    exp_t        mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_subtractor #(.WIDTH(8), .STEP(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
        .bin(bin_v[0]), .busy(busy0), .done(done0), .diff(diff0), .bout(bout0), .ovf(ovf0));
    serial_subtractor #(.WIDTH(8), .STEP(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]),
        .bin(bin_v[1]), .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1));
    serial_subtractor #(.WIDTH(16), .STEP(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
        .bin(bin_v[2]), .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2));
    serial_subtractor #(.WIDTH(8), .STEP(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a_v[3][7:0]), .b(b_v[3][7:0]),
        .bin(bin_v[3]), .busy(busy3), .done(done3), .diff(diff3), .bout(bout3), .ovf(ovf3));

    always_comb begin
        busy_v[0] = busy0; busy_v[1] = busy1; busy_v[2] = busy2; busy_v[3] = busy3;
        done_v[0] = done0; done_v[1] = done1; done_v[2] = done2; done_v[3] = done3;
        diff_v[0] = {8'h00, diff0}; diff_v[1] = {8'h00, diff1};
        diff_v[2] = diff2;          diff_v[3] = {8'h00, diff3};
        bout_v[0] = bout0; bout_v[1] = bout1; bout_v[2] = bout2; bout_v[3] = bout3;
        ovf_v[0]  = ovf0;  ovf_v[1]  = ovf1;  ovf_v[2]  = ovf2;  ovf_v[3]  = ovf3;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: integer arithmetic for diff/bout, signed range test for ovf.
    function automatic exp_t model(input int k, input int ecyc,
                                   input logic [15:0] av, input logic [15:0] bv, input logic bi);
        exp_t m;
        int   w = WV[k];
        int   mask = (1 << w) - 1;
        int   ua = int'(av) & mask;
        int   ub = int'(bv) & mask;
        int   r = ua - ub - int'(bi);
        int   sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        int   sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        int   sr = sa - sb - int'(bi);
        m.exp_cyc = ecyc;
        m.diff    = 16'(r & mask);
        m.bout    = (r < 0);
        m.ovf     = (sr < -(1 << (w - 1))) || (sr >= (1 << (w - 1)));
        return m;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (done_v[k]) begin
                    done_cnt[k]++;
                    if (q[k].size() == 0) begin
                        check($sformatf("spurious_done%0d", k), 32'd1, 32'd0);
                    end else begin
                        mon_e = q[k].pop_front();
                        check($sformatf("diff%0d", k), 32'(diff_v[k]), 32'(mon_e.diff));
                        check($sformatf("bout%0d", k), 32'(bout_v[k]), 32'(mon_e.bout));
                        check($sformatf("ovf%0d", k), 32'(ovf_v[k]), 32'(mon_e.ovf));
                        check($sformatf("done_cycle%0d", k), 32'(cyc), 32'(mon_e.exp_cyc));
                        check($sformatf("busy_in_done%0d", k), 32'(busy_v[k]), 32'd0);
                        last_diff[k] = diff_v[k];
                    end
                end
            end
        end
    end

    // Drive one start pulse; operands are scrambled right after capture.
    task automatic issue(input int k, input logic [15:0] av, input logic [15:0] bv, input logic bi);
        @(negedge clk);
        start_v[k] = 1'b1;
        a_v[k] = av; b_v[k] = bv; bin_v[k] = bi;
        q[k].push_back(model(k, cyc + 1 + NV[k], av, bv, bi));
        @(negedge clk);
        start_v[k] = 1'b0;
        a_v[k] = 16'($urandom); b_v[k] = 16'($urandom); bin_v[k] = 1'($urandom);
    endtask

    task automatic wait_idle(input int k);
        for (int i = 0; i < 100 && q[k].size() != 0; i++) @(negedge clk);
        check($sformatf("drain%0d", k), 32'(q[k].size()), 32'd0);
    endtask

    initial begin
        int t_acc;
        int d_before;
        exp_t e1;
        for (int k = 0; k < 4; k++) begin
            start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; bin_v[k] = 1'b0;
            done_cnt[k] = 0; last_diff[k] = '0;
        end

        #3;
        for (int k = 0; k < 4; k++) begin
            check("rst_busy", 32'(busy_v[k]), 32'd0);
            check("rst_done", 32'(done_v[k]), 32'd0);
            check("rst_diff", 32'(diff_v[k]), 32'd0);
            check("rst_bout", 32'(bout_v[k]), 32'd0);
            check("rst_ovf",  32'(ovf_v[k]),  32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic vectors, WIDTH=8 STEP=1
        issue(0, 16'h05, 16'h03, 1'b0); wait_idle(0);
        issue(0, 16'h00, 16'h00, 1'b1); wait_idle(0);
        issue(0, 16'h03, 16'h05, 1'b0); wait_idle(0);

        // WIDTH=8 STEP=2
        issue(1, 16'h80, 16'h01, 1'b0); wait_idle(1);
        issue(1, 16'h7F, 16'hFF, 1'b0); wait_idle(1);

        // STEP=WIDTH: single RUN cycle
        issue(3, 16'hFF, 16'h00, 1'b0); wait_idle(3);
        issue(3, 16'h00, 16'h00, 1'b1); wait_idle(3);
        issue(3, 16'h80, 16'h7F, 1'b1); wait_idle(3);

        // Start mid-RUN is ignored; diff holds the previous result meanwhile
        issue(0, 16'h40, 16'h11, 1'b1);
        @(negedge clk);
        start_v[0] = 1'b1; a_v[0] = 16'hAA; b_v[0] = 16'h55; bin_v[0] = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        check("hold_diff", 32'(diff_v[0]), 32'(last_diff[0]));
        check("busy_run", 32'(busy_v[0]), 32'd1);
        wait_idle(0);
        repeat (12) @(negedge clk);

        // start held through done: second op accepted in the done cycle
        @(negedge clk);
        start_v[0] = 1'b1; a_v[0] = 16'h12; b_v[0] = 16'h34; bin_v[0] = 1'b0;
        e1 = model(0, cyc + 1 + 8, 16'h12, 16'h34, 1'b0);
        q[0].push_back(e1);
        @(negedge clk);
        a_v[0] = 16'h9C; b_v[0] = 16'h21; bin_v[0] = 1'b1;
        q[0].push_back(model(0, e1.exp_cyc + 9, 16'h9C, 16'h21, 1'b1));
        for (int i = 0; i < 50 && cyc < e1.exp_cyc + 1; i++) @(negedge clk);
        start_v[0] = 1'b0;
        wait_idle(0);

        // Asynchronous reset three cycles into RUN
        issue(0, 16'h03, 16'h05, 1'b0);
        t_acc = q[0][0].exp_cyc - 8;
        for (int i = 0; i < 50 && cyc < t_acc + 3; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy_v[0]), 32'd0);
        check("arst_done", 32'(done_v[0]), 32'd0);
        check("arst_diff", 32'(diff_v[0]), 32'd0);
        check("arst_bout", 32'(bout_v[0]), 32'd0);
        check("arst_ovf",  32'(ovf_v[0]),  32'd0);
        q[0].delete();
        d_before = done_cnt[0];
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("no_done_after_rst", 32'(done_cnt[0]), 32'(d_before));
        issue(0, 16'hC8, 16'h37, 1'b0); wait_idle(0);

        // Random, WIDTH=16 STEP=4
        issue(2, 16'hFFFF, 16'h0000, 1'b0); wait_idle(2);
        issue(2, 16'h0000, 16'h0000, 1'b1); wait_idle(2);
        for (int n = 0; n < 500; n++) begin
            issue(2, 16'($urandom), 16'($urandom), 1'($urandom));
            wait_idle(2);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
